// File: rtl/adder_seq_mc.sv
// adder_seq_mc: multi-operand sequential adder/subtractor.
//
// The block holds a bank of DEPTH operand registers that are loaded through a
// simple write handshake. A start pulse launches a reduction over a masked
// subset of the bank, processing one operand per clock.
//
// Ports:
//   i_clk    clock, all logic on the rising edge
//   i_rstn   synchronous active-low reset
//   i_addr   operand register index for writes
//   i_data   write data
//   i_we     write enable (accepted in IDLE only)
//   i_start  start a reduction (accepted in IDLE only)
//   i_mode   0: sum of selected regs; 1: reg[0] minus the other selected regs
//   i_mask   participation mask, bit i selects reg[i]
//   o_data   result, held until the next completion or reset
//   o_ovf    sticky overflow/underflow of the last reduction
//   o_ready  one-cycle pulse when o_data/o_ovf are new
//   o_ack    one-cycle pulse acknowledging an accepted write
//   o_busy   high while a reduction is in progress (RUN and DONE)
module adder_seq_mc #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SAT   = 0,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [AW-1:0]    i_addr,
  input  logic [N-1:0]     i_data,
  input  logic             i_we,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [DEPTH-1:0] i_mask,
  output logic [N-1:0]     o_data,
  output logic             o_ovf,
  output logic             o_ready,
  output logic             o_ack,
  output logic             o_busy
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       regs_q [DEPTH];
  logic [N-1:0]       acc_q, acc_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic               mode_q, mode_d;
  logic [DEPTH-1:0]   mask_q, mask_d;
  logic [N-1:0]       data_q, data_d;
  logic               res_ovf_q, res_ovf_d;
  logic               ack_q, ack_d;
  logic               wr_en;

  logic [N-1:0]       opnd;
  logic [N:0]         sum;
  logic [N:0]         diff;
  logic [N-1:0]       step_acc;
  logic               step_carry;

  // Single reduction step on the operand currently indexed by idx_q.
  always_comb begin
    opnd       = regs_q[idx_q];
    sum        = {1'b0, acc_q} + {1'b0, opnd};
    diff       = {1'b0, acc_q} - {1'b0, opnd};
    step_acc   = acc_q;
    step_carry = 1'b0;
    if (mask_q[idx_q]) begin
      if (!mode_q) begin
        step_carry = sum[N];
        step_acc   = (SAT != 0 && step_carry) ? '1 : sum[N-1:0];
      end else if (idx_q == '0) begin
        // Subtraction seeds the accumulator with the minuend.
        step_acc = opnd;
      end else begin
        step_carry = diff[N];
        step_acc   = (SAT != 0 && step_carry) ? '0 : diff[N-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    data_d    = data_q;
    res_ovf_d = res_ovf_q;
    ack_d     = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_we) begin
          wr_en = 1'b1;
          ack_d = 1'b1;
        end
        // The write lands at this edge, before the first RUN read.
        if (i_start) begin
          mode_d  = i_mode;
          mask_d  = i_mask;
          acc_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = step_acc;
        ovf_d = ovf_q | step_carry;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          data_d    = step_acc;
          res_ovf_d = ovf_q | step_carry;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      mode_q    <= 1'b0;
      mask_q    <= '0;
      data_q    <= '0;
      res_ovf_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      res_ovf_q <= res_ovf_d;
      ack_q     <= ack_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[i_addr] <= i_data;
    end
  end

  assign o_data  = data_q;
  assign o_ovf   = res_ovf_q;
  assign o_ack   = ack_q;
  assign o_ready = (state_q == StDone);
  assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_adder_seq_mc.sv
// Bench for adder_seq_mc: two instances (wrap and saturate) share stimulus and
// are checked every cycle against a behavioural model, plus literal results.
module tb_adder_seq_mc;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic [1:0] i_addr = '0;
  logic [7:0] i_data = '0;
  logic       i_we = 1'b0;
  logic       i_start = 1'b0;
  logic       i_mode = 1'b0;
  logic [3:0] i_mask = '0;

  logic [7:0] o_data0, o_data1;
  logic       o_ovf0, o_ovf1, o_ready0, o_ready1, o_ack0, o_ack1, o_busy0, o_busy1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  adder_seq_mc #(.N(N), .DEPTH(DEPTH), .SAT(0)) u_wrap (
    .i_clk(clk), .i_rstn(i_rstn), .i_addr(i_addr), .i_data(i_data), .i_we(i_we),
    .i_start(i_start), .i_mode(i_mode), .i_mask(i_mask), .o_data(o_data0), .o_ovf(o_ovf0),
    .o_ready(o_ready0), .o_ack(o_ack0), .o_busy(o_busy0)
  );

  adder_seq_mc #(.N(N), .DEPTH(DEPTH), .SAT(1)) u_sat (
    .i_clk(clk), .i_rstn(i_rstn), .i_addr(i_addr), .i_data(i_data), .i_we(i_we),
    .i_start(i_start), .i_mode(i_mode), .i_mask(i_mask), .o_data(o_data1), .o_ovf(o_ovf1),
    .o_ready(o_ready1), .o_ack(o_ack1), .o_busy(o_busy1)
  );

  // Model state: operand mirror, cycles left in the current operation,
  // pending and published results for the wrap (0) and saturate (1) variants.
  int         m_regs [4];
  int         m_cnt = 0;
  bit         m_ack = 0;
  logic [8:0] m_pend0, m_pend1;
  logic [7:0] m_data0 = '0, m_data1 = '0;
  bit         m_ovf0 = 0, m_ovf1 = 0;

  function automatic logic [8:0] reduce(input int r[4], input bit mode, input logic [3:0] mask,
                                        input bit sat);
    int s;
    bit ov;
    ov = 0;
    if (!mode) begin
      s = 0;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          s += r[i];
          if (s > 255) begin
            ov = 1;
            s  = sat ? 255 : s - 256;
          end
        end
      end
    end else begin
      s = mask[0] ? r[0] : 0;
      for (int i = 1; i < 4; i++) begin
        if (mask[i]) begin
          s -= r[i];
          if (s < 0) begin
            ov = 1;
            s  = sat ? 0 : s + 256;
          end
        end
      end
    end
    return {ov, 8'(s)};
  endfunction

  task automatic model_step();
    if (!i_rstn) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
      m_cnt = 0; m_ack = 0;
      m_data0 = '0; m_data1 = '0; m_ovf0 = 0; m_ovf1 = 0;
    end else begin
      m_ack = 0;
      if (m_cnt == 0) begin
        if (i_we) begin
          m_regs[i_addr] = int'(i_data);
          m_ack = 1;
        end
        if (i_start) begin
          m_pend0 = reduce(m_regs, i_mode, i_mask, 0);
          m_pend1 = reduce(m_regs, i_mode, i_mask, 1);
          m_cnt   = DEPTH + 1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 1) begin
          m_data0 = m_pend0[7:0]; m_ovf0 = m_pend0[8];
          m_data1 = m_pend1[7:0]; m_ovf1 = m_pend1[8];
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    check("ack0",   int'(o_ack0),   int'(m_ack));
    check("ack1",   int'(o_ack1),   int'(m_ack));
    check("busy0",  int'(o_busy0),  int'(m_cnt > 0));
    check("busy1",  int'(o_busy1),  int'(m_cnt > 0));
    check("ready0", int'(o_ready0), int'(m_cnt == 1));
    check("ready1", int'(o_ready1), int'(m_cnt == 1));
    check("data0",  int'(o_data0),  int'(m_data0));
    check("data1",  int'(o_data1),  int'(m_data1));
    check("ovf0",   int'(o_ovf0),   int'(m_ovf0));
    check("ovf1",   int'(o_ovf1),   int'(m_ovf1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wr(input int a, input int d);
    i_we = 1'b1; i_addr = 2'(a); i_data = 8'(d);
    tick();
    i_we = 1'b0;
  endtask

  // Launches a reduction, optionally disturbs it mid-run, checks latency and
  // literal results, and pokes start during DONE (must be ignored).
  task automatic run_op(input string name, input bit mode, input logic [3:0] mask,
                        input bit disturb, input int e0, input int v0, input int e1,
                        input int v1);
    int k;
    bit got;
    i_mode = mode; i_mask = mask; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_we = 1'b0;
    i_mode = ~mode; i_mask = ~mask;  // captured values must be used
    k = 0; got = 0;
    while (!got && k < 20) begin
      if (disturb && k == 1) begin
        i_we = 1'b1; i_addr = 2'd1; i_data = 8'd99; i_start = 1'b1;
      end
      tick();
      k++;
      i_we = 1'b0; i_start = 1'b0;
      if (o_ready0) got = 1;
    end
    check({name, "_lat"}, k, DEPTH);
    check({name, "_d0"}, int'(o_data0), e0);
    check({name, "_v0"}, int'(o_ovf0), v0);
    check({name, "_d1"}, int'(o_data1), e1);
    check({name, "_v1"}, int'(o_ovf1), v1);
    i_start = 1'b1; i_mode = 1'b0; i_mask = 4'hF;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    int rdy_seen;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    tick();
    tick();
    check("rst_data", int'(o_data0), 0);
    check("rst_busy", int'(o_busy0), 0);
    i_rstn = 1'b1;
    tick();

    wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
    tick();
    run_op("add_all", 0, 4'b1111, 0, 100, 0, 100, 0);

    wr(0, 200); wr(1, 100); wr(2, 0); wr(3, 0);
    run_op("add_ovf", 0, 4'b1111, 0, 44, 1, 255, 1);

    wr(0, 50); wr(1, 10); wr(2, 5); wr(3, 7);
    run_op("sub_ok", 1, 4'b0111, 0, 35, 0, 35, 0);

    wr(0, 5); wr(1, 10);
    run_op("sub_unf", 1, 4'b0011, 0, 251, 1, 0, 1);

    wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
    run_op("mask0101", 0, 4'b0101, 0, 40, 0, 40, 0);
    run_op("mask0000", 0, 4'b0000, 0, 0, 0, 0, 0);

    run_op("busy_ign", 0, 4'b1111, 1, 100, 0, 100, 0);
    run_op("reg1_kept", 0, 4'b1111, 0, 100, 0, 100, 0);

    // Same-cycle write and start: ack plus write-before-read.
    i_we = 1'b1; i_addr = 2'd0; i_data = 8'd7;
    run_op("wr_start", 0, 4'b1111, 0, 97, 0, 97, 0);

    // Reset two cycles into RUN abandons the run.
    i_mode = 1'b0; i_mask = 4'hF; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    i_rstn = 1'b0;
    tick();
    check("rst_mid_data", int'(o_data0), 0);
    check("rst_mid_busy", int'(o_busy1), 0);
    i_rstn = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_ready0 || o_ready1) rdy_seen++;
    end
    check("rst_no_ready", rdy_seen, 0);
    run_op("after_rst", 0, 4'b1111, 0, 0, 0, 0, 0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
